otp_display_scan: RTL



---
 rtl/otp_display_scan.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/otp_display_scan.sv
// otp_display_scan: time-multiplexed seven-segment driver for the OTP authenticator.
// Converts the selected OTP to BCD with an iterative double-dabble, overlays
// lock/unlock/expire glyphs and scans NUM_DIGITS digits over one segment bus.
// Optional build macro OTP_DISP_LZ_BLANK_EN blanks leading zeros in normal mode.
module otp_display_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  unlock,
  input  logic                  lock,
  input  logic                  expire,
  input  logic [1:0]            wrng_att,
  input  logic                  show_lfsr,
  input  logic [DATA_W-1:0]     user_otp,
  input  logic [DATA_W-1:0]     lfsr_otp,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  ovf
);

  // Enough BCD digits for any DATA_W value, and at least one per scanned digit.
  localparam int unsigned BCD_MIN = (DATA_W * 3) / 10 + 1;
  localparam int unsigned BCD_D   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int unsigned BCD_W   = 4 * BCD_D;
  localparam int unsigned SH_W    = BCD_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(DATA_W);
  localparam int unsigned REF_W   = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [6:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                  state, state_n;
  logic [SH_W-1:0]         sh, sh_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [DATA_W-1:0]       cap, cap_n;
  logic [DATA_W-1:0]       last, last_n;
  logic [BCD_W-1:0]        disp, disp_n;
  logic                    start_req, start_req_n;
  logic                    ovf_n;
  logic [REF_W-1:0]        ref_cnt, ref_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [DATA_W-1:0]       src;

  assign src = show_lfsr ? lfsr_otp : user_otp;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int unsigned i = 0; i < BCD_D; i++) begin
      if (t[DATA_W+4*i +: 4] >= 4'd5) t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  // Any nonzero BCD digit beyond the scanned digits means the value cannot be shown.
  function automatic logic bcd_ovf(input logic [BCD_W-1:0] b);
    logic r;
    r = 1'b0;
    for (int unsigned i = NUM_DIGITS; i < BCD_D; i++) begin
      if (b[4*i +: 4] != 4'd0) r = 1'b1;
    end
    return r;
  endfunction

  // Active-high {g..a} decimal glyphs; out-of-range codes blank.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Converter next-state: capture on change, shift DATA_W times, commit in DONE.
  always_comb begin
    state_n     = state;
    sh_n        = sh;
    cnt_n       = cnt;
    cap_n       = cap;
    last_n      = last;
    disp_n      = disp;
    ovf_n       = ovf;
    start_req_n = start_req;
    case (state)
      S_IDLE: begin
        if (start_req || (src != last)) begin
          sh_n        = {BCD_W'(0), src};
          cap_n       = src;
          cnt_n       = '0;
          start_req_n = 1'b0;
          state_n     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_n  = dd_step(sh);
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        disp_n  = sh[SH_W-1:DATA_W];
        ovf_n   = bcd_ovf(sh[SH_W-1:DATA_W]);
        last_n  = cap;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Scan next-state and glyph selection for the current slot.
  always_comb begin
    logic [6:0] g;
    logic [3:0] digit;
    logic       msd;
    logic       lz;
    ref_n = ref_cnt + REF_W'(1);
    idx_n = idx;
    if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_n = '0;
      idx_n = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
    digit = disp[{idx, 2'b00} +: 4];
    msd   = (idx == IDX_W'(NUM_DIGITS - 1));
    lz    = 1'b0;
`ifdef OTP_DISP_LZ_BLANK_EN
    lz = (idx != '0);
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= idx) && (disp[4*j +: 4] != 4'd0)) lz = 1'b0;
    end
`endif
    if (expire)      g = 7'h79;
    else if (lock)   g = msd ? 7'h38 : ((idx == '0) ? dec7({2'b00, wrng_att}) : 7'h00);
    else if (unlock) g = msd ? 7'h3E : 7'h00;
    else if (ovf)    g = 7'h40;
    else if (lz)     g = 7'h00;
    else             g = dec7(digit);
    seg_n = (SEG_ACTIVE_LOW != 0) ? ~g : g;
    an_n  = NUM_DIGITS'(1) << idx;
    if (SEG_ACTIVE_LOW != 0) an_n = ~an_n;
  end

  // All state and outputs; reset aborts any conversion and forces a fresh one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      sh        <= '0;
      cnt       <= '0;
      cap       <= '0;
      last      <= '0;
      disp      <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      start_req <= 1'b1;
      ref_cnt   <= '0;
      idx       <= '0;
      seg       <= SEG_OFF;
      an        <= AN_OFF;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      cap       <= cap_n;
      last      <= last_n;
      disp      <= disp_n;
      ovf       <= ovf_n;
      busy      <= (state_n == S_SHIFT);
      start_req <= start_req_n;
      ref_cnt   <= ref_n;
      idx       <= idx_n;
      seg       <= seg_n;
      an        <= an_n;
    end
  end

endmodule
